// File: rtl/adc_sched_pkg.sv
// Shared definitions for the ADC sample scheduler: FSM encoding,
// default timing constants and a constant-foldable clog2 helper.
package adc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        STORE = 2'd3
    } sched_state_t;

    // 100 MHz / 2268 is roughly 44.1 kHz
    localparam int DIV_44K1    = 2268;
    localparam int TIMEOUT_DEF = 4096;

    // Smallest r with 2**r >= n
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small register-based FIFO with a combinational head (first-word
// latency of one cycle after push). A push into a full FIFO is only
// accepted when a pop happens in the same cycle. DEPTH must be a
// power of two so the pointers wrap naturally.
module sample_fifo
    import adc_sched_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    valid,
    output logic                    full,
    output logic [clog2(DEPTH):0]   fill
);

    localparam int AW = clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      fill_reg;
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign valid   = (fill_reg != '0);
    assign full    = (fill_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = entry_q[rd_ptr_reg];
    assign fill    = fill_reg;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            fill_reg <= fill_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // One storage register per entry, written when the write pointer selects it
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                entry_reg <= din;
            end
        end
        assign entry_q[gi] = entry_reg;
    end

endmodule

// File: rtl/adc_sample_scheduler.sv
// ADC sample scheduler: periodic conversion requests, synchronised
// done handshake, sample capture into a FIFO and sticky error flags.
// Optional macro ADC_SCHED_AVG_EN: average sample pairs before pushing.
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int DIV     = DIV_44K1,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int DEPTH   = 4
) (
    input  logic                  clk100MHz,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_err,
    input  logic                  adc_listo,
    input  logic [WIDTH-1:0]      adc_dato,
    output logic                  adc_inicio,
    output logic [WIDTH-1:0]      sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic [clog2(DEPTH):0] fill,
    output logic                  err_late,
    output logic                  err_overrun,
    output logic                  err_timeout
);

    localparam int CW = clog2(DIV);
    localparam int TW = clog2(TIMEOUT);

    logic [CW-1:0]    tick_cnt_reg;
    logic             tick;
    logic             sync1_reg, sync2_reg, sync_d_reg;
    logic             listo_rise;
    sched_state_t     state_reg, state_next;
    logic [TW-1:0]    to_cnt_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             inicio_reg;
    logic             capture, store, timeout_hit, late_evt, overrun_evt;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             fifo_full;
    logic             err_late_reg, err_overrun_reg, err_timeout_reg;

    assign tick       = enable && (tick_cnt_reg == CW'(DIV - 1));
    assign listo_rise = sync2_reg & ~sync_d_reg;

    // Sample-rate divider; held at zero while sampling is disabled
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset)                           tick_cnt_reg <= '0;
        else if (!enable || tick)            tick_cnt_reg <= '0;
        else                                 tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end

    // Two-flop synchroniser for the foreign-timed done level, plus edge history
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            sync_d_reg <= 1'b0;
        end else begin
            sync1_reg  <= adc_listo;
            sync2_reg  <= sync1_reg;
            sync_d_reg <= sync2_reg;
        end
    end

    // Next-state and per-state strobes; a done edge beats a simultaneous timeout
    always_comb begin
        state_next  = state_reg;
        capture     = 1'b0;
        store       = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE:  if (tick) state_next = REQ;
            REQ:   state_next = WAIT;
            WAIT: begin
                if (listo_rise) begin
                    capture    = 1'b1;
                    state_next = STORE;
                end else if (to_cnt_reg == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            STORE: begin
                store      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, registered request level, timeout counter and capture register
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            inicio_reg <= 1'b0;
            to_cnt_reg <= '0;
            hold_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            inicio_reg <= (state_next == REQ) || (state_next == WAIT);
            if (state_reg == REQ)       to_cnt_reg <= '0;
            else if (state_reg == WAIT) to_cnt_reg <= to_cnt_reg + 1'b1;
            if (capture)                hold_reg   <= adc_dato;
        end
    end

`ifdef ADC_SCHED_AVG_EN
    logic             phase_reg;
    logic             enable_d_reg;
    logic [WIDTH:0]   acc_reg;
    logic [WIDTH:0]   pair_sum;

    assign pair_sum  = acc_reg + {1'b0, hold_reg};
    assign push      = store && phase_reg;
    assign push_data = pair_sum[WIDTH:1];

    // Pair phase: first sample parks in the accumulator, second pushes the mean
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            phase_reg    <= 1'b0;
            enable_d_reg <= 1'b0;
            acc_reg      <= '0;
        end else begin
            enable_d_reg <= enable;
            if ((enable_d_reg && !enable) || timeout_hit) begin
                phase_reg <= 1'b0;
            end else if (store) begin
                if (!phase_reg) acc_reg <= {1'b0, hold_reg};
                phase_reg <= ~phase_reg;
            end
        end
    end
`else
    assign push      = store;
    assign push_data = hold_reg;
`endif

    assign late_evt    = tick && (state_reg != IDLE);
    assign overrun_evt = push && fifo_full && !sample_ready;

    // Sticky error flags; a set event wins over a same-cycle clear
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            err_late_reg    <= 1'b0;
            err_overrun_reg <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            err_late_reg    <= late_evt    | (err_late_reg    & ~clear_err);
            err_overrun_reg <= overrun_evt | (err_overrun_reg & ~clear_err);
            err_timeout_reg <= timeout_hit | (err_timeout_reg & ~clear_err);
        end
    end

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk100MHz),
        .rst   (reset),
        .push  (push),
        .pop   (sample_ready),
        .din   (push_data),
        .dout  (sample_data),
        .valid (sample_valid),
        .full  (fifo_full),
        .fill  (fill)
    );

    assign adc_inicio  = inicio_reg;
    assign err_late    = err_late_reg;
    assign err_overrun = err_overrun_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed testbench for adc_sample_scheduler (DIV=20, TIMEOUT=32, DEPTH=4).
module tb_adc_sample_scheduler;

    localparam int WIDTH   = 12;
    localparam int DIV     = 20;
    localparam int TIMEOUT = 32;
    localparam int DEPTH   = 4;

    logic             clk100MHz = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             clear_err = 1'b0;
    logic             adc_listo;
    logic [WIDTH-1:0] adc_dato;
    logic             adc_inicio;
    logic [WIDTH-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready = 1'b0;
    logic [2:0]       fill;
    logic             err_late, err_overrun, err_timeout;
    logic [2:0]       errs;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    // ADC model controls
    bit adc_answer = 1'b1;
    int adc_delay  = 10;
    int adc_base   = 0;
    int adc_step   = 1;
    int conv_num   = 0;

    int ta, tb, tc, tv;

    adc_sample_scheduler #(
        .WIDTH(WIDTH), .DIV(DIV), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)
    ) dut (
        .clk100MHz    (clk100MHz),
        .reset        (reset),
        .enable       (enable),
        .clear_err    (clear_err),
        .adc_listo    (adc_listo),
        .adc_dato     (adc_dato),
        .adc_inicio   (adc_inicio),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fill         (fill),
        .err_late     (err_late),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout)
    );

    assign errs = {err_late, err_overrun, err_timeout};

    always #5 clk100MHz = ~clk100MHz;
    always @(posedge clk100MHz) cyc <= cyc + 1;

    // ADC model: raise listo adc_delay cycles after inicio rises, drop it when inicio drops
    initial begin
        int count;
        count     = 0;
        adc_listo = 1'b0;
        adc_dato  = '0;
        forever begin
            @(posedge clk100MHz);
            #1;
            if (!adc_inicio) begin
                adc_listo = 1'b0;
                count     = 0;
            end else if (adc_answer && !adc_listo) begin
                count++;
                if (count > adc_delay) begin
                    adc_listo = 1'b1;
                    adc_dato  = 12'(adc_base + conv_num * adc_step);
                    conv_num++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for inicio (sel=0) or sample_valid (sel=1) to reach lvl
    task automatic wait_sig(input string tag, input int sel, input logic lvl,
                            input int limit, output int t);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            @(negedge clk100MHz);
            n++;
            if (((sel == 0) ? adc_inicio : sample_valid) == lvl) ok = 1'b1;
        end
        chk({tag, "_wait"}, 32'(ok), 32'd1);
        t = cyc;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clk100MHz);
        #1;
        reset    = 1'b0;
        conv_num = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk100MHz);
        chk("rst_inicio", 32'(adc_inicio), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_errs", 32'(errs), 32'd0);
        chk("rst_data", 32'(sample_data), 32'd0);

`ifdef ADC_SCHED_AVG_EN
        // Pair averaging: 100 and 201 give a single 150
        adc_base = 100; adc_step = 101; adc_delay = 3; conv_num = 0;
        sample_ready = 1'b1;
        enable = 1'b1;
        wait_sig("avg", 1, 1'b1, 100, tv);
        chk("avg_data", 32'(sample_data), 32'd150);
        @(negedge clk100MHz);
        chk("avg_single", 32'(fill), 32'd0);
`else
        // Basic: request every 20 cycles, sample 14 cycles after request
        adc_base = 12'hABC; adc_step = 1; adc_delay = 10; adc_answer = 1'b1;
        sample_ready = 1'b1;
        enable = 1'b1;
        wait_sig("b_req0", 0, 1'b1, 60, ta);
        wait_sig("b_val0", 1, 1'b1, 30, tv);
        chk("b_latency", 32'(tv - ta), 32'd14);
        chk("b_data0", 32'(sample_data), 32'hABC);
        wait_sig("b_req1", 0, 1'b1, 30, tb);
        chk("b_period", 32'(tb - ta), 32'd20);
        wait_sig("b_val1", 1, 1'b1, 30, tv);
        chk("b_data1", 32'(sample_data), 32'hABD);
        chk("b_errs", 32'(errs), 32'd0);

        // Timeout: ADC silent, inicio high REQ + TIMEOUT cycles
        do_reset();
        adc_answer = 1'b0;
        enable = 1'b1;
        wait_sig("t_req", 0, 1'b1, 60, ta);
        wait_sig("t_end", 0, 1'b0, 50, tb);
        chk("t_inicio_len", 32'(tb - ta), 32'd33);
        chk("t_errs", 32'(errs), 32'b101);
        wait_sig("t_rereq", 0, 1'b1, 30, tc);
        chk("t_rereq_gap", 32'(tc - tb), 32'd7);

        // Late tick: 25-cycle answer overlaps the next tick
        do_reset();
        adc_answer = 1'b1; adc_delay = 25; adc_base = 12'h300; adc_step = 1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_sig("l_val", 1, 1'b1, 80, tv);
            chk("l_data", 32'(sample_data), 32'(12'h300 + i));
        end
        chk("l_errs", 32'(errs), 32'b100);

        // Reset mid-WAIT with a sample queued and a sticky flag set
        sample_ready = 1'b0;
        wait_sig("r_req0", 0, 1'b1, 60, ta);
        wait_sig("r_end0", 0, 1'b0, 40, tb);
        wait_sig("r_req1", 0, 1'b1, 60, tc);
        repeat (3) @(negedge clk100MHz);
        chk("r_pre_inicio", 32'(adc_inicio), 32'd1);
        chk("r_pre_valid", 32'(sample_valid), 32'd1);
        chk("r_pre_errs", 32'(errs), 32'b100);
        #2;
        reset = 1'b1;
        #1;
        chk("r_inicio", 32'(adc_inicio), 32'd0);
        chk("r_valid", 32'(sample_valid), 32'd0);
        chk("r_fill", 32'(fill), 32'd0);
        chk("r_errs", 32'(errs), 32'd0);
        do_reset();

        // Overrun: six conversions into a 4-deep FIFO with no consumer
        adc_delay = 2; adc_base = 12'h100; adc_step = 1; conv_num = 0;
        sample_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_sig("o_req", 0, 1'b1, 60, ta);
            wait_sig("o_end", 0, 1'b0, 20, tb);
        end
        @(posedge clk100MHz);
        #1;
        enable = 1'b0;
        @(negedge clk100MHz);
        chk("o_fill", 32'(fill), 32'd4);
        chk("o_errs", 32'(errs), 32'b010);
        @(posedge clk100MHz); #1; clear_err = 1'b1;
        @(posedge clk100MHz); #1; clear_err = 1'b0;
        @(negedge clk100MHz);
        chk("o_cleared", 32'(errs), 32'd0);

        // Full FIFO, push and pop in the same STORE cycle
        enable = 1'b1;
        wait_sig("s_req", 0, 1'b1, 60, ta);
        wait_sig("s_store", 0, 1'b0, 20, tb);
        chk("s_head", 32'(sample_data), 32'h100);
        sample_ready = 1'b1;
        @(posedge clk100MHz);
        #1;
        sample_ready = 1'b0;
        enable = 1'b0;
        @(negedge clk100MHz);
        chk("s_fill", 32'(fill), 32'd4);
        chk("s_errs", 32'(errs), 32'd0);
        sample_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [11:0] exp_v;
            exp_v = (i == 3) ? 12'h106 : 12'(12'h101 + i);
            chk("s_drain_valid", 32'(sample_valid), 32'd1);
            chk("s_drain_data", 32'(sample_data), 32'(exp_v));
            @(negedge clk100MHz);
        end
        chk("s_empty", 32'(sample_valid), 32'd0);
        chk("s_fill0", 32'(fill), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
- Sequences the serial ADC receiver: issues conversion requests (`adc_inicio`) at a fixed sample rate derived from `clk100MHz`, waits for `adc_listo`, captures `adc_dato`.
- Buffers samples in a small FIFO with a valid/ready output to downstream DSP/display logic.
- Flags sticky errors: late tick, FIFO overrun, ADC timeout.
- Sits between the ADC receive module and any sample consumer.

Parameters:
- `WIDTH`, 12, sample width in bits.
- `DIV`, 2268, clk100MHz cycles per sample tick (~44.1 kHz).
- `TIMEOUT`, 4096, max cycles waiting for `adc_listo` after request.
- `DEPTH`, 4, FIFO entries (power of two, ≥2).

Ports:
- `clk100MHz`, in, 1, system clock.
- `reset`, in, 1, asynchronous, active-high reset.
- `enable`, in, 1, run sampling; 0 = tick counter held at 0, no new requests.
- `clear_err`, in, 1, one-cycle pulse clears sticky error flags.
- `adc_listo`, in, 1, ADC done level (foreign timing; synchronised internally).
- `adc_dato`, in, `WIDTH`, ADC result, stable while `adc_listo`=1.
- `adc_inicio`, out, 1, conversion request level to ADC.
- `sample_data`, out, `WIDTH`, FIFO head.
- `sample_valid`, out, 1, FIFO non-empty.
- `sample_ready`, in, 1, consumer accepts head when valid&ready.
- `fill`, out, clog2(`DEPTH`)+1, FIFO occupancy.
- `err_late`, out, 1, sticky: tick arrived while FSM not IDLE.
- `err_overrun`, out, 1, sticky: sample dropped, FIFO full.
- `err_timeout`, out, 1, sticky: no `adc_listo` within `TIMEOUT`.

Behaviour:
- Reset (async, any state): all outputs 0; FSM IDLE; tick counter, FIFO pointers, timeout counter 0; sync flops 0.
- Tick counter:
  - counts 0..`DIV`-1 while `enable`=1; `tick` is a 1-cycle pulse at `DIV`-1, then wraps to 0.
  - `enable`=0 clears the counter; the FSM finishes any in-flight conversion.
- `adc_listo` passes through a 2-flop synchroniser; `listo_rise` = sync & ~sync_d. Latency from pin to `listo_rise` is 2–3 cycles.
- FSM:
  - IDLE: `tick` → REQ.
  - REQ: `adc_inicio`=1; clear timeout counter; → WAIT next cycle.
  - WAIT: `adc_inicio`=1; timeout counter +1 per cycle.
    - `listo_rise` → STORE; `adc_dato` captured this cycle into the hold register.
    - counter = `TIMEOUT`-1 without `listo_rise` → set `err_timeout`, → IDLE.
    - If both occur in the same cycle, `listo_rise` wins.
  - STORE: `adc_inicio`=0; push hold register to FIFO; → IDLE.
- `adc_inicio` is registered; it is 1 exactly in REQ and WAIT.
- Tick while FSM ≠ IDLE: tick dropped, `err_late` set; the FSM is not disturbed.
- FIFO:
  - Push in STORE; pop when `sample_valid`&`sample_ready`.
  - Full and push with no pop: sample dropped, `err_overrun` set, contents unchanged.
  - Full, push and pop in the same cycle: both occur; `fill` stays `DEPTH`.
  - Empty: `sample_valid`=0, `sample_data` holds the last value (don't-care).
  - Push to empty: `sample_valid` high the next cycle (first-word latency 1 cycle after STORE).
  - Pointers wrap modulo `DEPTH`.
- Sticky flags:
  - set events override `clear_err` in the same cycle;
  - cleared only by `clear_err` or `reset`.
- Reset mid-conversion: `adc_inicio` drops immediately (async); FIFO contents lost.

Optional Feature:
- Macro `ADC_SCHED_AVG_EN`.
- Defined:
  - STORE alternates between accumulate and push.
  - First sample is held in an accumulator (`WIDTH`+1 bits).
  - Second sample: push (acc + new) >> 1, truncating; output rate is halved.
  - Accumulator phase resets on `reset` and when `enable` falls.
  - A timeout discards a pending half-pair.
- Undefined: every sample is pushed unmodified.

Decomposition:
- Package `adc_sched_pkg`:
  - FSM state encoding (IDLE=0, REQ=1, WAIT=2, STORE=3);
  - default constants `DIV_44K1`=2268 and `TIMEOUT_DEF`=4096;
  - `clog2` helper function.
- Sub-module `sample_fifo` (parameters `WIDTH`, `DEPTH`):
  - ports: push, pop, din, dout, valid, full, fill;
  - reused elsewhere for the UART/display paths.

Test Plan:
- Basic: `DIV`=20; `enable`=1; ADC model raises `listo` 10 cycles after `inicio` with `dato`=0xABC; `ready`=1.
  - Expect `adc_inicio` pulse train every 20 cycles.
  - Expect `sample_valid` with 0xABC about 14 cycles after each tick; no errors.
- Overrun: `ready`=0, 6 conversions, `DEPTH`=4.
  - Expect `fill`=4 and `err_overrun`=1.
  - Expect popped order = first 4 data values.
  - Expect `clear_err` to zero the flag.
- Timeout: `TIMEOUT`=8, ADC never answers.
  - Expect `adc_inicio` high for exactly 9 cycles (REQ + 8 WAIT).
  - Expect `err_timeout`=1, FSM back to IDLE, next tick requests again.
- Late tick: `DIV`=10, ADC answers after 15 cycles.
  - Expect `err_late`=1.
  - Expect one sample stored per conversion, none lost from the FIFO.
- Simultaneous full push/pop: FIFO full, `ready`=1 in the STORE cycle.
  - Expect `fill` stays 4, no overrun, new sample at the tail.
- Reset mid-WAIT: assert `reset` asynchronously between clocks.
  - Expect `adc_inicio`, `sample_valid` and flags 0 before the next clock edge.
  - With `ADC_SCHED_AVG_EN`, samples 100 and 201 → single output 150.
